// File: rtl/gate_seq_pkg.sv
// Shared encodings and constants for the gate test sequencer.
package gate_seq_pkg;

  localparam int unsigned OP_W     = 3;
  localparam int unsigned VEC_W    = 2;
  localparam int unsigned ERR_W    = 3;
  localparam int unsigned SETTLE_W = 4;
  localparam int unsigned NUM_VECS = 4;

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(NUM_VECS);

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic logic op_is_legal(input op_e op);
    return (op <= OP_XNOR);
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model: expected gate output for a given op and inputs.
module gate_ref_model
  import gate_seq_pkg::*;
(
  input  op_e  op_i,
  input  logic a_i,
  input  logic b_i,
  output logic exp_c
);

  always_comb begin
    exp_c = 1'b0;
    case (op_i)
      OP_AND:  exp_c = a_i & b_i;
      OP_OR:   exp_c = a_i | b_i;
      OP_NAND: exp_c = ~(a_i & b_i);
      OP_NOR:  exp_c = ~(a_i | b_i);
      OP_XOR:  exp_c = a_i ^ b_i;
      OP_XNOR: exp_c = ~(a_i ^ b_i);
      default: exp_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_test_sequencer.sv
// Exhaustive 2-input gate tester: steps {a,b} through 00..11, checks c after settling.
// Optional first-failure log enabled by defining GATE_SEQ_ERRLOG_EN.
module gate_test_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  output logic             a,
  output logic             b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             bad_op
`ifdef GATE_SEQ_ERRLOG_EN
  ,
  output logic             first_fail_valid,
  output logic [VEC_W-1:0] first_fail_vec
`endif
);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic                a_q, a_d, b_q, b_d;
  logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                bad_q, bad_d;
  logic                exp_c;
  logic                mismatch_c;
`ifdef GATE_SEQ_ERRLOG_EN
  logic                ffv_q, ffv_d;
  logic [VEC_W-1:0]    ffvec_q, ffvec_d;
`endif

  gate_ref_model u_ref (
    .op_i  (op_q),
    .a_i   (vec_q[1]),
    .b_i   (vec_q[0]),
    .exp_c (exp_c)
  );

  assign mismatch_c = (c != exp_c);

  // Next-state and next-output logic; outputs are derived from the next state.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    bad_d   = bad_q;
`ifdef GATE_SEQ_ERRLOG_EN
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          op_d  = op_e'(op);
          err_d = '0;
`ifdef GATE_SEQ_ERRLOG_EN
          ffv_d   = 1'b0;
          ffvec_d = '0;
`endif
          if (op_is_legal(op_e'(op))) begin
            bad_d   = 1'b0;
            vec_d   = '0;
            state_d = ST_DRIVE;
          end else begin
            bad_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DRIVE: begin
        cnt_d   = '0;
        state_d = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + SETTLE_W'(1);
        end
      end
      ST_CHECK: begin
        if (mismatch_c) begin
          if (err_q < ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
`ifdef GATE_SEQ_ERRLOG_EN
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = vec_q;
          end
`endif
        end
        if (vec_q == LAST_VEC) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + VEC_W'(1);
          state_d = ST_DRIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_DRIVE) || (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_d == '0) && !bad_d;
    if (state_d == ST_DRIVE) begin
      a_d = vec_d[1];
      b_d = vec_d[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_AND;
      vec_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      bad_q   <= 1'b0;
`ifdef GATE_SEQ_ERRLOG_EN
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      bad_q   <= bad_d;
`ifdef GATE_SEQ_ERRLOG_EN
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
`endif
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign bad_op    = bad_q;
`ifdef GATE_SEQ_ERRLOG_EN
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
`endif

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: two instances (SETTLE_CYCLES=2 and 0),
// each driving a bench-side gate whose type is selectable per scenario.
module tb_gate_test_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       start2, a2, b2, c2, busy2, done2, pass2, bad2;
  logic [2:0] op2, err2, gate2;
  logic       start0, a0, b0, c0, busy0, done0, pass0, bad0;
  logic [2:0] op0, err0, gate0;
`ifdef GATE_SEQ_ERRLOG_EN
  logic       ffv2, ffv0;
  logic [1:0] ffvec2, ffvec0;
`endif

  int n_cmp;
  int n_err;

  // Gate standing in for the device under test, selected per scenario.
  function automatic logic gate_fn(input logic [2:0] g, input logic x, input logic y);
    case (g)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return ~(x & y);
      3'd3:    return ~(x | y);
      3'd4:    return x ^ y;
      3'd5:    return ~(x ^ y);
      default: return 1'b0;
    endcase
  endfunction

  assign c2 = gate_fn(gate2, a2, b2);
  assign c0 = gate_fn(gate0, a0, b0);

  gate_test_sequencer #(.SETTLE_CYCLES(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .op        (op2),
    .a         (a2),
    .b         (b2),
    .c         (c2),
    .busy      (busy2),
    .done      (done2),
    .pass      (pass2),
    .err_count (err2),
    .bad_op    (bad2)
`ifdef GATE_SEQ_ERRLOG_EN
    ,
    .first_fail_valid (ffv2),
    .first_fail_vec   (ffvec2)
`endif
  );

  gate_test_sequencer #(.SETTLE_CYCLES(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start0),
    .op        (op0),
    .a         (a0),
    .b         (b0),
    .c         (c0),
    .busy      (busy0),
    .done      (done0),
    .pass      (pass0),
    .err_count (err0),
    .bad_op    (bad0)
`ifdef GATE_SEQ_ERRLOG_EN
    ,
    .first_fail_valid (ffv0),
    .first_fail_vec   (ffvec0)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start2 = 1'b0; start0 = 1'b0;
    op2 = 3'd0; op0 = 3'd0; gate2 = 3'd0; gate0 = 3'd1;
    repeat (3) tick();
    n_cmp++;
    if ({a2, b2, busy2, done2, pass2, bad2, err2} !== 9'b0) begin
      n_err++;
      $display("FAIL reset_dut2: got %b want %b", {a2, b2, busy2, done2, pass2, bad2, err2}, 9'b0);
    end
    n_cmp++;
    if ({a0, b0, busy0, done0, pass0, bad0, err0} !== 9'b0) begin
      n_err++;
      $display("FAIL reset_dut0: got %b want %b", {a0, b0, busy0, done0, pass0, bad0, err0}, 9'b0);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if ({busy2, done2, busy0, done0} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_idle: got %b want %b", {busy2, done2, busy0, done0}, 4'b0);
    end
  endtask

  task automatic test_and_pass();
    logic [1:0] ev;
    op2 = 3'd0; gate2 = 3'd0; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ev = 2'(k / 4);
      n_cmp++;
      if ({a2, b2} !== ev) begin
        n_err++;
        $display("FAIL and_ab[%0d]: got %b want %b", k, {a2, b2}, ev);
      end
      n_cmp++;
      if ({busy2, done2} !== 2'b10) begin
        n_err++;
        $display("FAIL and_busy_done[%0d]: got %b want %b", k, {busy2, done2}, 2'b10);
      end
      tick();
    end
    n_cmp++;
    if ({done2, pass2, busy2, bad2} !== 4'b1100) begin
      n_err++;
      $display("FAIL and_final_flags: got %b want %b", {done2, pass2, busy2, bad2}, 4'b1100);
    end
    n_cmp++;
    if (err2 !== 3'd0) begin
      n_err++;
      $display("FAIL and_err: got %0d want %0d", err2, 0);
    end
    n_cmp++;
    if ({a2, b2} !== 2'b11) begin
      n_err++;
      $display("FAIL and_hold_ab: got %b want %b", {a2, b2}, 2'b11);
    end
  endtask

  task automatic test_xor_fail();
    op2 = 3'd4; gate2 = 3'd0; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (8) tick();
    n_cmp++;
    if (err2 !== 3'd1) begin
      n_err++;
      $display("FAIL xor_err_mid: got %0d want %0d", err2, 1);
    end
    repeat (7) tick();
    n_cmp++;
    if ({done2, err2} !== {1'b0, 3'd2}) begin
      n_err++;
      $display("FAIL xor_before_done: got done=%b err=%0d want done=0 err=2", done2, err2);
    end
    tick();
    n_cmp++;
    if ({done2, pass2, bad2} !== 3'b100) begin
      n_err++;
      $display("FAIL xor_flags: got %b want %b", {done2, pass2, bad2}, 3'b100);
    end
    n_cmp++;
    if (err2 !== 3'd3) begin
      n_err++;
      $display("FAIL xor_err: got %0d want %0d", err2, 3);
    end
`ifdef GATE_SEQ_ERRLOG_EN
    n_cmp++;
    if ({ffv2, ffvec2} !== 3'b101) begin
      n_err++;
      $display("FAIL xor_first_fail: got %b want %b", {ffv2, ffvec2}, 3'b101);
    end
`endif
  endtask

  task automatic test_bad_op();
    op2 = 3'd6; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n_cmp++;
    if ({done2, bad2, pass2, busy2} !== 4'b1100) begin
      n_err++;
      $display("FAIL badop_flags: got %b want %b", {done2, bad2, pass2, busy2}, 4'b1100);
    end
    n_cmp++;
    if (err2 !== 3'd0) begin
      n_err++;
      $display("FAIL badop_err: got %0d want %0d", err2, 0);
    end
    n_cmp++;
    if ({a2, b2} !== 2'b11) begin
      n_err++;
      $display("FAIL badop_ab: got %b want %b", {a2, b2}, 2'b11);
    end
`ifdef GATE_SEQ_ERRLOG_EN
    n_cmp++;
    if (ffv2 !== 1'b0) begin
      n_err++;
      $display("FAIL badop_ffv: got %b want %b", ffv2, 1'b0);
    end
`endif
    tick();
    n_cmp++;
    if ({done2, bad2} !== 2'b11) begin
      n_err++;
      $display("FAIL badop_hold: got %b want %b", {done2, bad2}, 2'b11);
    end
  endtask

  task automatic test_mid_reset();
    op2 = 3'd0; gate2 = 3'd0; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (9) tick();
    n_cmp++;
    if ({a2, b2, busy2} !== 3'b101) begin
      n_err++;
      $display("FAIL rst_pre: got %b want %b", {a2, b2, busy2}, 3'b101);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a2, b2, busy2, done2, pass2, bad2, err2} !== 9'b0) begin
      n_err++;
      $display("FAIL rst_async: got %b want %b", {a2, b2, busy2, done2, pass2, bad2, err2}, 9'b0);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    n_cmp++;
    if ({done2, busy2, a2, b2} !== 4'b0) begin
      n_err++;
      $display("FAIL rst_no_resume: got %b want %b", {done2, busy2, a2, b2}, 4'b0);
    end
  endtask

  task automatic test_start_held();
    op2 = 3'd1; gate2 = 3'd0; start2 = 1'b1;
    tick();
    repeat (4) tick();
    n_cmp++;
    if ({a2, b2, busy2} !== 3'b011) begin
      n_err++;
      $display("FAIL held_ignored: got %b want %b", {a2, b2, busy2}, 3'b011);
    end
    repeat (12) tick();
    n_cmp++;
    if ({done2, busy2, pass2, err2} !== {3'b100, 3'd2}) begin
      n_err++;
      $display("FAIL held_first_done: got %b want %b", {done2, busy2, pass2, err2}, {3'b100, 3'd2});
    end
    tick();
    n_cmp++;
    if ({done2, busy2, a2, b2, err2} !== {4'b0100, 3'd0}) begin
      n_err++;
      $display("FAIL held_restart: got %b want %b", {done2, busy2, a2, b2, err2}, {4'b0100, 3'd0});
    end
    start2 = 1'b0;
    repeat (16) tick();
    n_cmp++;
    if ({done2, err2} !== {1'b1, 3'd2}) begin
      n_err++;
      $display("FAIL held_second_done: got %b want %b", {done2, err2}, {1'b1, 3'd2});
    end
  endtask

  task automatic test_settle0();
    logic [1:0] ev;
    op0 = 3'd1; gate0 = 3'd1; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ev = 2'(k / 2);
      n_cmp++;
      if ({a0, b0, done0} !== {ev, 1'b0}) begin
        n_err++;
        $display("FAIL s0_step[%0d]: got %b want %b", k, {a0, b0, done0}, {ev, 1'b0});
      end
      tick();
    end
    n_cmp++;
    if ({done0, pass0, busy0, err0} !== {3'b110, 3'd0}) begin
      n_err++;
      $display("FAIL s0_final: got %b want %b", {done0, pass0, busy0, err0}, {3'b110, 3'd0});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_and_pass();
    test_xor_fail();
    test_bad_op();
    test_mid_reset();
    test_start_held();
    test_settle0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gate_test_sequencer.md
GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 SHALL provide parameter SETTLE_CYCLES, default 2, giving the wait cycles between driving a vector and sampling the result (legal 0..15).
REQ-002 SHALL provide port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port start  input  1  run request, sampled only in IDLE or DONE.
REQ-005 SHALL provide port op  input  3  gate under test: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 reserved.
REQ-006 SHALL provide ports a and b  output  1 each  stimulus driven into the DUT gate.
REQ-007 SHALL provide port c  input  1  DUT gate output.
REQ-008 SHALL provide port busy  output  1  high from the DRIVE state through the CHECK state.
REQ-009 SHALL provide port done  output  1  high while in DONE.
REQ-010 SHALL provide port pass  output  1  valid when done=1; 1 when err_count=0 and op is legal.
REQ-011 SHALL provide port err_count  output  3  mismatches in the last run, range 0..4.
REQ-012 SHALL provide port bad_op  output  1  last start carried a reserved op.

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, SETTLE, CHECK and DONE.
REQ-014 SHALL latch op on the start edge, hold it for the run, and ignore op changes mid-run.
REQ-015 SHALL apply the vectors {a,b} in the order 00, 01, 10, 11 using a 2-bit vector counter.
REQ-016 SHALL handle IDLE/DONE with start=1 and a legal op as follows: clear err_count and bad_op, zero the vector counter, go to DRIVE.
REQ-017 SHALL handle IDLE/DONE with start=1 and a reserved op as follows: go to DONE next cycle with bad_op=1, pass=0, err_count=0, and a/b unchanged.
REQ-018 SHALL handle DRIVE as follows: a/b take the current vector; go to SETTLE, or to CHECK directly when SETTLE_CYCLES=0.
REQ-019 SHALL handle SETTLE as follows: remain exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-020 SHALL handle CHECK as follows: compare c with the expected value for the latched op and vector, and increment err_count on mismatch (saturate at 4).
REQ-021 SHALL handle the CHECK exit as follows: at vector 11 go to DONE; otherwise increment the vector counter and go to DRIVE.
REQ-022 SHALL make each vector take exactly SETTLE_CYCLES+2 cycles, so done rises 4*(SETTLE_CYCLES+2) cycles after the start-sampling edge.
REQ-023 SHALL hold done, pass and err_count in DONE until the next accepted start.
REQ-024 SHALL ignore start while busy=1.
REQ-025 SHALL hold a/b at the last vector in DONE.

Reset
REQ-026 SHALL, on rst_n low and at any time including mid-run, immediately force state IDLE with a=0, b=0, busy=0, done=0, pass=0, err_count=0, bad_op=0, vector counter 0 and latched op 0.
REQ-027 SHALL discard a run interrupted by reset; a new start is required after release.

Configuration
REQ-028 SHALL, when macro GATE_SEQ_ERRLOG_EN is defined, add outputs first_fail_valid (1 bit) and first_fail_vec (2 bits) capturing the vector of the first mismatch in a run, both cleared on an accepted start and on reset.
REQ-029 SHALL, without GATE_SEQ_ERRLOG_EN, omit those ports and registers and leave all other behaviour identical.

Structure
REQ-030 SHALL place the op encodings, the FSM state encoding and the vector-count constant (4) in shared package gate_seq_pkg.
REQ-031 SHALL place the expected-output function (op, a, b -> expected c) in sub-module gate_ref_model, which is purely combinational and instanced once.

Verification
REQ-032 SHALL verify: op=0 with a correct AND DUT, SETTLE_CYCLES=2, start pulse -> a/b step 00,01,10,11; done after 16 cycles; pass=1; err_count=0.
REQ-033 SHALL verify: op=4 with the DUT replaced by an AND gate -> mismatches at 01, 10 and 11; err_count=3; pass=0; first_fail_vec=01 when the macro is on.
REQ-034 SHALL verify: op=6 start -> done the next cycle; bad_op=1; pass=0; a/b unchanged.
REQ-035 SHALL verify: rst_n pulsed low during the SETTLE of vector 10 -> all outputs 0 immediately; IDLE after release; no done until a new start.
REQ-036 SHALL verify: start held high throughout a run -> ignored while busy; a new run is accepted on the first DONE cycle and err_count is cleared.
REQ-037 SHALL verify: SETTLE_CYCLES=0 with op=1 -> each vector takes 2 cycles; done after 8 cycles; pass=1.
